// File: rtl/gpio_pkg.sv
// Shared register map and helpers for the GPIO port controller.
// Optional build macro GPIO_DEBOUNCE_EN lengthens the edge-detect warm-up.
package gpio_pkg;

  localparam int GPIO_ADDR_W   = 3;

  localparam int GPIO_DOUT     = 0;
  localparam int GPIO_DIR      = 1;
  localparam int GPIO_DIN      = 2;
  localparam int GPIO_IRQ_EN   = 3;
  localparam int GPIO_RISE_EN  = 4;
  localparam int GPIO_FALL_EN  = 5;
  localparam int GPIO_IRQ_STAT = 6;

  // Cycles after reset release during which edges are ignored: the input path
  // must fill with real pin values before prev/level comparisons mean anything.
  function automatic int gpio_warmup(input int sync_stages, input int deb_cycles,
                                     input bit deb_en);
    return sync_stages + 1 + (deb_en ? deb_cycles : 0);
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// One pin: synchroniser, optional debounce (GPIO_DEBOUNCE_EN), edge history and
// registered rise/fall pulses.
module gpio_in_sync #(
  parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
  ,
  parameter int DEB_CYCLES  = 16
`endif
) (
  input  logic Clk,
  input  logic Reset,
  input  logic pin,
  input  logic edge_en,
  input  logic rise_en,
  input  logic fall_en,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_last;
  logic                   prev_p1;
  logic                   rise_p2;
  logic                   fall_p2;

  // Stage 0: metastability chain
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pin};
    end
  end

  assign sync_last = sync_p0[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] deb_cnt_p1;
  logic             level_p1;

  // Stage 1: level follows the synchroniser only after DEB_CYCLES stable cycles
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      deb_cnt_p1 <= '0;
      level_p1   <= 1'b0;
    end else if (sync_last == level_p1) begin
      deb_cnt_p1 <= '0;
    end else if (deb_cnt_p1 == CNT_W'(DEB_CYCLES - 1)) begin
      level_p1   <= sync_last;
      deb_cnt_p1 <= '0;
    end else begin
      deb_cnt_p1 <= deb_cnt_p1 + 1'b1;
    end
  end

  assign level = level_p1;
`else
  assign level = sync_last;
`endif

  // Stage 2: edge history and registered edge pulses
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prev_p1 <= 1'b0;
      rise_p2 <= 1'b0;
      fall_p2 <= 1'b0;
    end else begin
      prev_p1 <= level;
      rise_p2 <= edge_en & level & ~prev_p1 & rise_en;
      fall_p2 <= edge_en & ~level & prev_p1 & fall_en;
    end
  end

  assign rise = rise_p2;
  assign fall = fall_p2;

endmodule

// File: rtl/gpio_port_ctrl.sv
// Memory-mapped GPIO port: direction, synchronised inputs, edge capture, sticky
// W1C status and level irq. Build macro GPIO_DEBOUNCE_EN enables per-pin debounce.
module gpio_port_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = GPIO_ADDR_W,
  parameter int DEB_CYCLES  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_wr,
  input  logic [WIDTH-1:0]  bus_wdata,
  input  logic              bus_rd,
  output logic [WIDTH-1:0]  bus_rdata,
  output logic              bus_rvalid,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

`ifdef GPIO_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  localparam int WARM   = gpio_warmup(SYNC_STAGES, DEB_CYCLES, DEB_EN);
  localparam int WARM_W = $clog2(WARM + 1);

  logic [WIDTH-1:0]  dout;
  logic [WIDTH-1:0]  dir;
  logic [WIDTH-1:0]  irq_en;
  logic [WIDTH-1:0]  rise_en;
  logic [WIDTH-1:0]  fall_en;
  logic [WIDTH-1:0]  irq_stat;
  logic [WIDTH-1:0]  din;
  logic [WIDTH-1:0]  rise;
  logic [WIDTH-1:0]  fall;
  logic [WIDTH-1:0]  stat_clr;
  logic [WIDTH-1:0]  rd_mux;
  logic [WARM_W-1:0] warm_cnt;
  logic              edge_en;
  logic              wr_dout;
  logic              wr_dir;
  logic              wr_irq_en;
  logic              wr_rise_en;
  logic              wr_fall_en;
  logic              wr_stat;

  // Warm-up: hold edge detection off until the input path holds real pin data
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      warm_cnt <= '0;
    end else if (warm_cnt != WARM_W'(WARM)) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  assign edge_en = (warm_cnt == WARM_W'(WARM));

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_in_sync #(
      .SYNC_STAGES (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
      ,
      .DEB_CYCLES  (DEB_CYCLES)
`endif
    ) u_sync (
      .Clk     (Clk),
      .Reset   (Reset),
      .pin     (gpio_in[i]),
      .edge_en (edge_en),
      .rise_en (rise_en[i]),
      .fall_en (fall_en[i]),
      .level   (din[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  always_comb begin
    wr_dout    = bus_wr && (bus_addr == ADDR_W'(GPIO_DOUT));
    wr_dir     = bus_wr && (bus_addr == ADDR_W'(GPIO_DIR));
    wr_irq_en  = bus_wr && (bus_addr == ADDR_W'(GPIO_IRQ_EN));
    wr_rise_en = bus_wr && (bus_addr == ADDR_W'(GPIO_RISE_EN));
    wr_fall_en = bus_wr && (bus_addr == ADDR_W'(GPIO_FALL_EN));
    wr_stat    = bus_wr && (bus_addr == ADDR_W'(GPIO_IRQ_STAT));
    stat_clr   = wr_stat ? bus_wdata : '0;
  end

  // Register file: writes land on the bus_wr edge
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      dout     <= '0;
      dir      <= '0;
      irq_en   <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      irq_stat <= '0;
    end else begin
      if (wr_dout)    dout    <= bus_wdata;
      if (wr_dir)     dir     <= bus_wdata;
      if (wr_irq_en)  irq_en  <= bus_wdata;
      if (wr_rise_en) rise_en <= bus_wdata;
      if (wr_fall_en) fall_en <= bus_wdata;
      // A fresh edge outranks a simultaneous clear so no event is lost.
      irq_stat <= (irq_stat & ~stat_clr) | rise | fall;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      ADDR_W'(GPIO_DOUT):     rd_mux = dout;
      ADDR_W'(GPIO_DIR):      rd_mux = dir;
      ADDR_W'(GPIO_DIN):      rd_mux = din;
      ADDR_W'(GPIO_IRQ_EN):   rd_mux = irq_en;
      ADDR_W'(GPIO_RISE_EN):  rd_mux = rise_en;
      ADDR_W'(GPIO_FALL_EN):  rd_mux = fall_en;
      ADDR_W'(GPIO_IRQ_STAT): rd_mux = irq_stat;
      default:                rd_mux = '0;
    endcase
  end

  // Read stage: sampled from pre-write registers, data held until next read
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bus_rvalid <= 1'b0;
      bus_rdata  <= '0;
    end else begin
      bus_rvalid <= bus_rd;
      if (bus_rd) bus_rdata <= rd_mux;
    end
  end

  assign gpio_oe  = dir;
  assign gpio_out = dout & dir;
  assign irq      = |(irq_stat & irq_en);

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Bench for gpio_port_ctrl: read responses checked by a queue-based monitor,
// pin-side outputs checked directly. Honours GPIO_DEBOUNCE_EN when defined.
module tb_gpio_port_ctrl;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int DEB   = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT   = SYNC + 1 + DEB;
`else
  localparam int LAT   = SYNC + 1;
`endif
  localparam int SETTLE = LAT + 4;

  logic             Clk;
  logic             Reset;
  logic [2:0]       bus_addr;
  logic             bus_wr;
  logic [WIDTH-1:0] bus_wdata;
  logic             bus_rd;
  logic [WIDTH-1:0] bus_rdata;
  logic             bus_rvalid;
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] gpio_out;
  logic [WIDTH-1:0] gpio_oe;
  logic             irq;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  gpio_port_ctrl #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC),
    .ADDR_W      (3),
    .DEB_CYCLES  (DEB)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .bus_addr   (bus_addr),
    .bus_wr     (bus_wr),
    .bus_wdata  (bus_wdata),
    .bus_rd     (bus_rd),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .gpio_oe    (gpio_oe),
    .irq        (irq)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [WIDTH-1:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    cyc();
    bus_wr    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [WIDTH-1:0] e);
    bus_addr = a;
    bus_rd   = 1'b1;
    exp_q.push_back(e);
    cyc();
    bus_rd   = 1'b0;
  endtask

  // Monitor: every rvalid pops one expected read value
  always begin
    @(posedge Clk);
    #1;
    if (bus_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {{(WIDTH-1){1'b0}}, bus_rvalid}, '0);
      end else begin
        chk("read_data", bus_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset     = 1'b0;
    bus_addr  = '0;
    bus_wr    = 1'b0;
    bus_wdata = '0;
    bus_rd    = 1'b0;
    gpio_in   = '1;
    cyc(3);
    chk("rst_rvalid", {31'b0, bus_rvalid}, '0);
    chk("rst_rdata",  bus_rdata, '0);
    chk("rst_oe",     gpio_oe, '0);
    chk("rst_out",    gpio_out, '0);
    chk("rst_irq",    {31'b0, irq}, '0);

    // Pins already high at reset release must not raise status
    Reset = 1'b1;
    cyc(10 + LAT);
    rd(6, 32'h0);
    rd(2, 32'hFFFF_FFFF);

    wr(1, 32'h0000_FFFF);
    wr(0, 32'hA5A5_A5A5);
    chk("oe_dir",   gpio_oe,  32'h0000_FFFF);
    chk("out_mask", gpio_out, 32'h0000_A5A5);
    rd(0, 32'hA5A5_A5A5);
    rd(1, 32'h0000_FFFF);
    wr(7, 32'hDEAD_BEEF);
    rd(7, 32'h0);
    wr(2, 32'h0);
    rd(2, 32'hFFFF_FFFF);

    // Single-pin rise: status appears exactly LAT edges after sampling
    gpio_in = '0;
    cyc(SETTLE);
    wr(4, 32'h1);
    wr(3, 32'h1);
    rd(6, 32'h0);
    gpio_in[0] = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      cyc();
      chk("irq_latency_low", {31'b0, irq}, '0);
    end
    cyc();
    chk("irq_latency_high", {31'b0, irq}, 32'h1);
    rd(6, 32'h1);
    wr(6, 32'h1);
    chk("irq_w1c", {31'b0, irq}, '0);
    rd(6, 32'h0);

    // Edge lands on the same edge as its W1C: set wins
    gpio_in[0] = 1'b0;
    cyc(SETTLE);
    gpio_in[0] = 1'b1;
    cyc(LAT);
    wr(6, 32'h1);
    chk("set_wins_irq", {31'b0, irq}, 32'h1);
    rd(6, 32'h1);
    wr(6, 32'h1);
    chk("clear_after", {31'b0, irq}, '0);

    // Falling edge on pin 1 with rise disabled for that pin
    wr(5, 32'h2);
    wr(3, 32'h3);
    gpio_in[1] = 1'b1;
    cyc(SETTLE);
    rd(6, 32'h0);
    gpio_in[1] = 1'b0;
    cyc(SETTLE);
    rd(6, 32'h2);
    chk("fall_irq", {31'b0, irq}, 32'h1);
    wr(3, 32'h1);
    chk("irq_masked", {31'b0, irq}, '0);
    wr(6, 32'h2);
    rd(6, 32'h0);

    // Same-cycle read and write of DOUT returns the old value
    wr(0, 32'h12);
    bus_addr  = 3'd0;
    bus_wdata = 32'h34;
    bus_wr    = 1'b1;
    bus_rd    = 1'b1;
    exp_q.push_back(32'h12);
    cyc();
    bus_wr = 1'b0;
    bus_rd = 1'b0;
    rd(0, 32'h34);
    chk("out_new", gpio_out, 32'h34);
    cyc();
    chk("rvalid_one_cycle", {31'b0, bus_rvalid}, '0);
    chk("rdata_hold", bus_rdata, 32'h34);

    // Pin 3 glitch/pulse behaviour
    wr(4, 32'h9);
`ifdef GPIO_DEBOUNCE_EN
    gpio_in[3] = 1'b1;
    cyc(5);
    gpio_in[3] = 1'b0;
    cyc(SETTLE);
    rd(2, 32'h1);
    rd(6, 32'h0);
    gpio_in[3] = 1'b1;
    cyc(20);
    gpio_in[3] = 1'b0;
    cyc(SETTLE);
    rd(6, 32'h8);
`else
    gpio_in[3] = 1'b1;
    cyc();
    gpio_in[3] = 1'b0;
    cyc(SETTLE);
    rd(2, 32'h1);
    rd(6, 32'h8);
`endif
    wr(6, 32'h8);

    // Reset during a read: rvalid drops at once and the pending read vanishes
    bus_addr = 3'd0;
    bus_rd   = 1'b1;
    exp_q.push_back(32'h34);
    cyc();
    #2;
    Reset = 1'b0;
    #1;
    chk("rst_mid_rvalid", {31'b0, bus_rvalid}, '0);
    bus_rd = 1'b0;
    cyc(2);
    chk("rst_mid_rvalid2", {31'b0, bus_rvalid}, '0);
    chk("rst_mid_oe", gpio_oe, '0);
    Reset = 1'b1;
    cyc(10 + LAT);
    rd(1, 32'h0);
    rd(6, 32'h0);
    chk("post_rst_irq", {31'b0, irq}, '0);

    cyc(3);
    chk("scoreboard_drain", exp_q.size(), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
